cache_line_mover: RTL
=====================

# cache_line_mover

Block-transfer engine between the cache controller and main memory. Accepts one line-move request per transaction, collects a dirty victim line from the cache and writes it back word-by-word, then fetches the new line from memory and streams it to the cache for SRAM refill. Owns the 32-word block buffer and all `mem_*` handshaking, so the cache controller sees one request/done pair per miss.

## Interface
Parameters:
- DATA_WIDTH, 32, word width
- ADDR_WIDTH, 32, byte address width
- WORDS, 32, words per line (power of two)
- OFFSET_BITS, 7, byte-offset bits of a line (log2(WORDS*DATA_WIDTH/8))

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  clock, rising edge
- rst_n  in  1  async active-low reset
- req_valid  in  1  request strobe, sampled only when req_ready=1
- req_ready  out  1  engine idle, accepting requests
- req_wb  in  1  request includes writeback of victim line
- req_fill  in  1  request includes fill of new line
- req_wb_addr  in  ADDR_WIDTH  victim byte address (low OFFSET_BITS ignored)
- req_fill_addr  in  ADDR_WIDTH  miss byte address (bits [OFFSET_BITS-1:2] = critical word)
- wb_valid  in  1  cache presents victim word
- wb_ready  out  1  engine accepts victim word
- wb_data  in  DATA_WIDTH  victim word, in order 0..WORDS-1
- fill_valid  out  1  fill word valid
- fill_ready  in  1  cache accepts fill word
- fill_idx  out  log2(WORDS)  word index within line of fill_data
- fill_data  out  DATA_WIDTH  fill word
- done  out  1  one-cycle pulse, transaction complete
- mem_ren, mem_wen  out  1  memory read/write request, held until mem_ack
- mem_addr  out  ADDR_WIDTH  word-aligned memory byte address
- mem_din  out  DATA_WIDTH  write data to memory
- mem_dout  in  DATA_WIDTH  read data from memory, valid with mem_ack
- mem_ack  in  1  memory completes current request

## Operation
- States: IDLE, WB_COLLECT, WB_WRITE, FILL_READ, FILL_DRAIN, DONE.
- IDLE: req_ready=1. On req_valid: latch addresses (low OFFSET_BITS zeroed), flags; counter cnt=0; go WB_COLLECT if req_wb, else FILL_READ if req_fill, else DONE.
- WB_COLLECT: wb_ready=1; each wb_valid&wb_ready writes buf[cnt], cnt++. After word WORDS-1: cnt=0, go WB_WRITE.
- WB_WRITE: mem_wen=1, mem_addr=wb_base+4*cnt, mem_din=buf[cnt]. On mem_ack: cnt++; after last word go FILL_READ if req_fill else DONE.
- FILL_READ: mem_ren=1, mem_addr=fill_base+4*idx(cnt). On mem_ack: buf[idx(cnt)]<=mem_dout, cnt++; after last word go FILL_DRAIN, cnt=0.
- FILL_DRAIN: fill_valid=1, fill_idx=idx(cnt), fill_data=buf[idx(cnt)]; advance on fill_ready. After last word go DONE.
- DONE: done=1 for one cycle, go IDLE.
- idx(cnt)=cnt without CRITICAL_WORD_FIRST_EN; counter is log2(WORDS)+1 bits, terminal at WORDS-1.
- mem_ren and mem_wen never asserted together.

## Timing
- Reset (async assert): state IDLE, req_ready=1, wb_ready=0, fill_valid=0, fill_idx=0, fill_data=0, done=0, mem_ren=0, mem_wen=0, mem_addr=0, mem_din=0. Reset mid-transaction aborts immediately; buffer contents undefined; no done.
- All outputs registered. req accepted at edge N -> first state output at N+1.
- Memory: request held with stable addr/data until mem_ack sampled high; next word's addr presented on the following cycle with request still asserted (1 word/cycle max). mem_ack outside WB_WRITE/FILL_READ ignored.
- req_valid while req_ready=0 ignored (no queueing).
- Fill-only minimum latency with 1-cycle mem_ack and fill_ready=1: 1+WORDS*2+WORDS+1 cycles to done.
- fill_valid low with fill_ready high: no effect; fill_data held stable while fill_valid&!fill_ready.

## Configuration
- CRITICAL_WORD_FIRST_EN defined: idx(cnt)=(crit+cnt) mod WORDS where crit=req_fill_addr[OFFSET_BITS-1:2]; fill reads and drain start at the critical word and wrap to 0 after WORDS-1. Writeback order unaffected.
- Undefined: fill always word 0..WORDS-1 in order.

## Test plan
- Fill-only, req_fill_addr=0x0000_1234, mem_dout=addr, mem_ack 1 cycle after request -> 32 reads at 0x1200..0x127C, fill words idx0..31 = 0x1200..0x127C, one done pulse.
- Writeback+fill, wb_data=0xA000_0000+i, wb_addr=0x0000_4000 -> 32 writes at 0x4000..0x407C with data 0xA000_0000..0xA000_001F, then 32 reads, mem_ren/mem_wen never both high.
- Backpressure: fill_ready toggling 1/0, mem_ack delayed 3 cycles -> fill_data stable while stalled, no word lost or duplicated.
- Async rst_n low mid-WB_WRITE (word 10) -> mem_wen=0 immediately, req_ready=1, no done; new fill after release completes normally.
- req_wb=0, req_fill=0 -> done pulse 2 cycles after acceptance, no mem activity; req_valid during busy ignored.
- With CRITICAL_WORD_FIRST_EN, req_fill_addr=0x0000_107C -> first read 0x107C, then 0x1000..0x1078; fill_idx sequence 31,0,1..30.

Source files
------------

// File: rtl/cache_line_mover_if.sv
// cache_line_mover_if
//   Bundles every handshake/bus signal of the line mover: the request channel,
//   the victim-word stream, the fill-word stream, the done pulse and the
//   memory port.
//   modport master : the engine (drives req_ready, wb_ready, fill_*, done, mem_* requests)
//   modport slave  : the environment (cache controller + main memory)
interface cache_line_mover_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int WORDS      = 32
);
  localparam int IDX_W = $clog2(WORDS);

  logic                  req_valid;
  logic                  req_ready;
  logic                  req_wb;
  logic                  req_fill;
  logic [ADDR_WIDTH-1:0] req_wb_addr;
  logic [ADDR_WIDTH-1:0] req_fill_addr;

  logic                  wb_valid;
  logic                  wb_ready;
  logic [DATA_WIDTH-1:0] wb_data;

  logic                  fill_valid;
  logic                  fill_ready;
  logic [IDX_W-1:0]      fill_idx;
  logic [DATA_WIDTH-1:0] fill_data;

  logic                  done;

  logic                  mem_ren;
  logic                  mem_wen;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_din;
  logic [DATA_WIDTH-1:0] mem_dout;
  logic                  mem_ack;

  modport master (
    input  req_valid, req_wb, req_fill, req_wb_addr, req_fill_addr,
           wb_valid, wb_data, fill_ready, mem_dout, mem_ack,
    output req_ready, wb_ready, fill_valid, fill_idx, fill_data, done,
           mem_ren, mem_wen, mem_addr, mem_din
  );

  modport slave (
    output req_valid, req_wb, req_fill, req_wb_addr, req_fill_addr,
           wb_valid, wb_data, fill_ready, mem_dout, mem_ack,
    input  req_ready, wb_ready, fill_valid, fill_idx, fill_data, done,
           mem_ren, mem_wen, mem_addr, mem_din
  );
endinterface

// File: rtl/cache_line_mover.sv
// cache_line_mover
//   Block-transfer engine between the cache controller and main memory.
//   One request per miss: optionally collects the dirty victim line into the
//   block buffer and writes it back word by word, then optionally reads the
//   new line from memory and streams it to the cache, ending with a done pulse.
//   Ports:
//     clk   : clock, rising edge
//     rst_n : asynchronous active-low reset
//     bus   : cache_line_mover_if.master (request, victim stream, fill stream,
//             done, memory port)
//   Build option: define CRITICAL_WORD_FIRST_EN to start the fill reads and
//   drain at the missed word (req_fill_addr[OFFSET_BITS-1:2]) and wrap.
//   All outputs are registered; they are computed from next-state values so a
//   request accepted at edge N shows its first state's outputs right after N.
module cache_line_mover #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int WORDS       = 32,
  parameter int OFFSET_BITS = 7
) (
  input logic                clk,
  input logic                rst_n,
  cache_line_mover_if.master bus
);
  localparam int IDX_W = $clog2(WORDS);
  localparam logic [ADDR_WIDTH-1:0] LINE_MASK =
    ~ADDR_WIDTH'((64'd1 << OFFSET_BITS) - 64'd1);
  localparam logic [IDX_W:0] CNT_LAST = (IDX_W+1)'(WORDS - 1);

  typedef enum logic [2:0] {
    IDLE, WB_COLLECT, WB_WRITE, FILL_READ, FILL_DRAIN, DONE
  } state_e;

  state_e                state_q, state_d;
  logic [IDX_W:0]        cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] wb_base_q, wb_base_d, fill_base_q, fill_base_d;
  logic                  fill_en_q, fill_en_d;
  logic [IDX_W-1:0]      crit_d;
  logic                  accept, last;

  logic                  buf_we;
  logic [IDX_W-1:0]      buf_widx;
  logic [DATA_WIDTH-1:0] buf_wdata;
  logic [DATA_WIDTH-1:0] buf_q [WORDS];

  logic [IDX_W-1:0]      rd_idx, wr_idx;
  logic [DATA_WIDTH-1:0] fill_word, wb_word;

  logic                  req_ready_q, req_ready_d, wb_ready_q, wb_ready_d;
  logic                  fill_valid_q, fill_valid_d, done_q, done_d;
  logic [IDX_W-1:0]      fill_idx_q, fill_idx_d;
  logic [DATA_WIDTH-1:0] fill_data_q, fill_data_d, mem_din_q, mem_din_d;
  logic                  mem_ren_q, mem_ren_d, mem_wen_q, mem_wen_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;

  function automatic logic [IDX_W-1:0] idx_f(input logic [IDX_W-1:0] c,
                                             input logic [IDX_W-1:0] crit);
    return c + crit;  // wraps modulo WORDS
  endfunction

  assign accept = (state_q == IDLE) && bus.req_valid;
  assign last   = (cnt_q == CNT_LAST);

  assign wb_base_d   = accept ? (bus.req_wb_addr & LINE_MASK)   : wb_base_q;
  assign fill_base_d = accept ? (bus.req_fill_addr & LINE_MASK) : fill_base_q;
  assign fill_en_d   = accept ? bus.req_fill : fill_en_q;

`ifdef CRITICAL_WORD_FIRST_EN
  logic [IDX_W-1:0] crit_q;
  assign crit_d = accept ? bus.req_fill_addr[OFFSET_BITS-1:2] : crit_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) crit_q <= '0;
    else        crit_q <= crit_d;
  end
`else
  assign crit_d = '0;
`endif

  // State register and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      wb_base_q    <= '0;
      fill_base_q  <= '0;
      fill_en_q    <= 1'b0;
      req_ready_q  <= 1'b1;
      wb_ready_q   <= 1'b0;
      fill_valid_q <= 1'b0;
      fill_idx_q   <= '0;
      fill_data_q  <= '0;
      done_q       <= 1'b0;
      mem_ren_q    <= 1'b0;
      mem_wen_q    <= 1'b0;
      mem_addr_q   <= '0;
      mem_din_q    <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      wb_base_q    <= wb_base_d;
      fill_base_q  <= fill_base_d;
      fill_en_q    <= fill_en_d;
      req_ready_q  <= req_ready_d;
      wb_ready_q   <= wb_ready_d;
      fill_valid_q <= fill_valid_d;
      fill_idx_q   <= fill_idx_d;
      fill_data_q  <= fill_data_d;
      done_q       <= done_d;
      mem_ren_q    <= mem_ren_d;
      mem_wen_q    <= mem_wen_d;
      mem_addr_q   <= mem_addr_d;
      mem_din_q    <= mem_din_d;
    end
  end

  // Block buffer has no reset; contents are don't-care between transactions
  always_ff @(posedge clk) begin
    if (buf_we) buf_q[buf_widx] <= buf_wdata;
  end

  // Next-state and buffer-write logic
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    buf_we    = 1'b0;
    buf_widx  = '0;
    buf_wdata = '0;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          cnt_d = '0;
          if (bus.req_wb)        state_d = WB_COLLECT;
          else if (bus.req_fill) state_d = FILL_READ;
          else                   state_d = DONE;
        end
      end
      WB_COLLECT: begin
        if (bus.wb_valid) begin
          buf_we    = 1'b1;
          buf_widx  = cnt_q[IDX_W-1:0];
          buf_wdata = bus.wb_data;
          if (last) begin
            cnt_d   = '0;
            state_d = WB_WRITE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      WB_WRITE: begin
        if (bus.mem_ack) begin
          if (last) begin
            cnt_d   = '0;
            state_d = fill_en_q ? FILL_READ : DONE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      FILL_READ: begin
        if (bus.mem_ack) begin
          buf_we    = 1'b1;
          buf_widx  = idx_f(cnt_q[IDX_W-1:0], crit_d);
          buf_wdata = bus.mem_dout;
          if (last) begin
            cnt_d   = '0;
            state_d = FILL_DRAIN;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      FILL_DRAIN: begin
        if (bus.fill_ready) begin
          if (last) begin
            cnt_d   = '0;
            state_d = DONE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode from next state. Buffer reads forward the word being
  // written this cycle so the first word after a phase change is never stale.
  always_comb begin
    rd_idx       = idx_f(cnt_d[IDX_W-1:0], crit_d);
    wr_idx       = cnt_d[IDX_W-1:0];
    fill_word    = (buf_we && buf_widx == rd_idx) ? buf_wdata : buf_q[rd_idx];
    wb_word      = (buf_we && buf_widx == wr_idx) ? buf_wdata : buf_q[wr_idx];
    req_ready_d  = (state_d == IDLE);
    wb_ready_d   = (state_d == WB_COLLECT);
    fill_valid_d = 1'b0;
    fill_idx_d   = '0;
    fill_data_d  = '0;
    done_d       = (state_d == DONE);
    mem_ren_d    = 1'b0;
    mem_wen_d    = 1'b0;
    mem_addr_d   = '0;
    mem_din_d    = '0;
    case (state_d)
      WB_WRITE: begin
        mem_wen_d  = 1'b1;
        mem_addr_d = wb_base_d + ADDR_WIDTH'({wr_idx, 2'b00});
        mem_din_d  = wb_word;
      end
      FILL_READ: begin
        mem_ren_d  = 1'b1;
        mem_addr_d = fill_base_d + ADDR_WIDTH'({rd_idx, 2'b00});
      end
      FILL_DRAIN: begin
        fill_valid_d = 1'b1;
        fill_idx_d   = rd_idx;
        fill_data_d  = fill_word;
      end
      default: ;
    endcase
  end

  assign bus.req_ready  = req_ready_q;
  assign bus.wb_ready   = wb_ready_q;
  assign bus.fill_valid = fill_valid_q;
  assign bus.fill_idx   = fill_idx_q;
  assign bus.fill_data  = fill_data_q;
  assign bus.done       = done_q;
  assign bus.mem_ren    = mem_ren_q;
  assign bus.mem_wen    = mem_wen_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_din    = mem_din_q;
endmodule
